// File: rtl/c17_pkg.sv
// rtl/c17_pkg.sv - shared constants, FSM state type and C17 evaluation function
//
// Purpose: common definitions for the C17 array pipeline and its slices.
//   C17_NI / C17_NO : primary inputs / outputs per C17 slice
//   LFSR_POLY       : Galois feedback polynomial of the BIST pattern generator
//   MISR_TAP_*      : feedback taps of the 16-bit signature register
//   bist_state_e    : self-test controller states
//   c17_eval        : one C17 NAND network, {pi4..pi0} -> {po1,po0}
package c17_pkg;

  localparam int C17_NI = 5;
  localparam int C17_NO = 2;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  localparam int MISR_TAP_A = 15;
  localparam int MISR_TAP_B = 14;
  localparam int MISR_TAP_C = 12;
  localparam int MISR_TAP_D = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  function automatic logic [C17_NO-1:0] c17_eval(input logic [C17_NI-1:0] pi);
    logic n8;
    logic n9;
    logic n10;
    logic n11;
    n8  = ~(pi[2] & pi[3]);
    n9  = ~(pi[0] & pi[2]);
    n10 = ~(n8 & pi[4]);
    n11 = ~(pi[1] & n8);
    return {~(n11 & n10), ~(n9 & n11)};
  endfunction

endpackage

// File: rtl/c17_core.sv
// rtl/c17_core.sv - one combinational C17 slice
//
// Purpose: a single C17 NAND network, instantiated once per lane.
// Ports:
//   pi : in  5 bits {pi4,pi3,pi2,pi1,pi0}
//   po : out 2 bits {po1,po0}
module c17_core
  import c17_pkg::*;
(
  input  logic [C17_NI-1:0] pi,
  output logic [C17_NO-1:0] po
);

  assign po = c17_eval(pi);

endmodule

// File: rtl/c17_array_pipe.sv
// rtl/c17_array_pipe.sv - LANES C17 slices behind a STAGES-deep valid/ready pipeline with LFSR/MISR self-test
//
// Purpose: parallel C17 slices whose outputs are registered through STAGES
//   stages; a self-test controller can take over the slice inputs with an
//   LFSR pattern stream and compact the results into a 16-bit MISR.
// Ports:
//   clock      : in  rising-edge clock
//   reset_n    : in  asynchronous active-low reset
//   in_valid   : in  upstream valid
//   in_ready   : out upstream ready (stage 0 free and controller idle/done)
//   in_data    : in  5*LANES, lane i at [5i+4:5i]
//   out_valid  : out downstream valid (suppressed during self-test)
//   out_ready  : in  downstream ready
//   out_data   : out 2*LANES, lane i at [2i+1:2i]
//   bist_start : in  one-cycle self-test request
//   bist_busy  : out high in FLUSH, RUN and DRAIN
//   bist_done  : out high in DONE
//   bist_sig   : out MISR signature, valid while bist_done
module c17_array_pipe
  import c17_pkg::*;
#(
  parameter int          LANES  = 4,
  parameter int          STAGES = 2,
  parameter int          NPAT   = 64,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [C17_NI*LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C17_NO*LANES-1:0] out_data,
  input  logic                   bist_start,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic [15:0]            bist_sig
);

  localparam int IW = C17_NI * LANES;
  localparam int DW = C17_NO * LANES;

  bist_state_e state_q;
  bist_state_e state_d;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_next;
  logic [15:0] misr_q;
  logic [15:0] misr_d;
  logic [15:0] sig_q;
  logic [15:0] cnt_q;
  logic [2:0]  drain_q;

  logic [STAGES-1:0] vld_q;
  logic [DW-1:0]     dat_q [STAGES];
  logic [STAGES:0]   rdy;

  logic          bist_mode;
  logic          ctl_open;
  logic          src_valid;
  logic          last_fire;
  logic          flush_entry;
  logic [IW-1:0] bist_pat;
  logic [IW-1:0] core_in;
  logic [DW-1:0] core_out;
  logic [C17_NO-1:0] lane_x;

  // During RUN/DRAIN the pipeline is never back-pressured: results are
  // consumed by the MISR, not by the downstream port.
  assign bist_mode = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ctl_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    rdy = '0;
    rdy[STAGES] = bist_mode | out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld_q[k] | rdy[k+1];
    end
  end

  // Lane i sees the low LFSR bits with its lane index folded in, so lanes
  // receive distinct patterns from one generator.
  always_comb begin
    bist_pat = '0;
    for (int i = 0; i < LANES; i++) begin
      bist_pat[C17_NI*i +: C17_NI] = lfsr_q[4:0] ^ 5'(i);
    end
  end

  assign core_in   = (state_q == ST_RUN) ? bist_pat : in_data;
  assign src_valid = (state_q == ST_RUN) | (in_valid & in_ready);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    c17_core u_core (
      .pi (core_in[C17_NI*i +: C17_NI]),
      .po (core_out[C17_NO*i +: C17_NO])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        vld_q[0] <= src_valid;
        if (src_valid) begin
          dat_q[0] <= core_out;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            dat_q[k] <= dat_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1] & ~bist_mode;
  assign out_data  = dat_q[STAGES-1];

  // Only BIST results can occupy the pipeline in RUN/DRAIN because FLUSH
  // waits for it to empty and upstream is closed until DONE.
  assign last_fire = vld_q[STAGES-1] & bist_mode;

  always_comb begin
    lane_x = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x = lane_x ^ dat_q[STAGES-1][C17_NO*i +: C17_NO];
    end
    misr_d = {misr_q[14:0],
              misr_q[MISR_TAP_A] ^ misr_q[MISR_TAP_B] ^ misr_q[MISR_TAP_C] ^ misr_q[MISR_TAP_D]}
             ^ {14'b0, lane_x};
  end

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    bist_busy = 1'b0;
    bist_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rdy[0];
        if (bist_start) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        bist_busy = 1'b1;
        if (vld_q == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        bist_busy = 1'b1;
        if (cnt_q == 16'(NPAT - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        bist_busy = 1'b1;
        if (drain_q == 3'(STAGES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        in_ready  = rdy[0];
        bist_done = 1'b1;
        if (bist_start) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush_entry = ctl_open && (state_d == ST_FLUSH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      sig_q   <= '0;
    end else begin
      if (flush_entry) begin
        lfsr_q  <= SEED;
        misr_q  <= '0;
        cnt_q   <= '0;
        drain_q <= '0;
        sig_q   <= '0;
      end
      if (state_q == ST_RUN) begin
        lfsr_q <= lfsr_next;
        cnt_q  <= cnt_q + 16'd1;
      end
      if (last_fire) begin
        misr_q <= misr_d;
      end
      if (state_q == ST_DRAIN) begin
        drain_q <= drain_q + 3'd1;
      end
      // The final result leaves the pipe on the same edge DONE is entered.
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
        sig_q <= last_fire ? misr_d : misr_q;
      end
    end
  end

  assign bist_sig = sig_q;

endmodule

// File: tb/tb_c17_array_pipe.sv
// tb/tb_c17_array_pipe.sv - scoreboard testbench for c17_array_pipe
module tb_c17_array_pipe;
  import c17_pkg::*;

  localparam int          LANES  = 4;
  localparam int          STAGES = 2;
  localparam int          NPAT   = 64;
  localparam logic [31:0] SEED1  = 32'h1;
  localparam logic [31:0] SEED2  = 32'h2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        bist_start;
  logic        bist_busy;
  logic        bist_done;
  logic [15:0] bist_sig;

  logic        in_valid2;
  logic        in_ready2;
  logic [19:0] in_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [7:0]  out_data2;
  logic        bist_start2;
  logic        bist_busy2;
  logic        bist_done2;
  logic [15:0] bist_sig2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] sig_q[$];
  logic [15:0] last_sig;
  logic        done_prev;

  always #5 clock = ~clock;

  c17_array_pipe #(.LANES(LANES), .STAGES(STAGES), .NPAT(NPAT), .SEED(SEED1)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done), .bist_sig(bist_sig)
  );

  c17_array_pipe #(.LANES(LANES), .STAGES(STAGES), .NPAT(NPAT), .SEED(SEED2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .bist_start(bist_start2), .bist_busy(bist_busy2), .bist_done(bist_done2), .bist_sig(bist_sig2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] beat_model(input logic [19:0] d);
    logic [7:0] r;
    for (int i = 0; i < LANES; i++) r[2*i +: 2] = c17_eval(d[5*i +: 5]);
    return r;
  endfunction

  function automatic logic [15:0] bist_model(input logic [31:0] seed);
    logic [31:0] l;
    logic [15:0] m;
    logic [1:0]  x;
    logic [4:0]  li;
    l = seed;
    m = '0;
    for (int p = 0; p < NPAT; p++) begin
      x = '0;
      for (int i = 0; i < LANES; i++) begin
        li = 5'(i);
        x = x ^ c17_eval(l[4:0] ^ li);
      end
      m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {14'b0, x};
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    end
    return m;
  endfunction

  // Monitor: pops the scoreboard whenever a beat or a signature is presented.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h required no beat", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checks--;
          check("out_data", {24'b0, out_data}, {24'b0, e});
        end
      end
      if (bist_done && !done_prev) begin
        last_sig = bist_sig;
        if (sig_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sig_unexpected: got %h required none", bist_sig);
        end else begin
          logic [15:0] s;
          s = sig_q.pop_front();
          check("bist_sig", {16'b0, bist_sig}, {16'b0, s});
        end
      end
    end
    done_prev = reset_n ? bist_done : 1'b0;
  end

  task automatic send_one(input logic [19:0] d, input logic [7:0] e, input string name);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(e);
    @(negedge clock);
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, lat, STAGES);
  endtask

  task automatic send_stream(input logic [19:0] beats[$], input bit stall);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < beats.size() && cyc < 200) begin
      in_valid  = 1'b1;
      in_data   = beats[idx];
      out_ready = !(stall && cyc >= 3 && cyc <= 6);
      @(negedge clock);
      if (stall && cyc == 4) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (in_ready) begin
        exp_q.push_back(beat_model(beats[idx]));
        idx++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_all_sent", idx, beats.size());
  endtask

  task automatic run_bist(input bit push, input int req_lat, input string name);
    int lat;
    if (push) sig_q.push_back(bist_model(SEED1));
    bist_start = 1'b1;
    @(posedge clock); #1;
    bist_start = 1'b0;
    lat = -1;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clock);
      if (k == 1) check({name, "_busy"}, {31'b0, bist_busy}, 32'd1);
      if (bist_done) begin
        lat = k;
        break;
      end
    end
    check({name, "_done_latency"}, lat, req_lat);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [19:0] stream[$];
    logic [15:0] sig_a;
    logic [15:0] sig_b;
    int lat2;

    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; bist_start = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1; bist_start2 = 1'b0;
    done_prev = 1'b0;
    last_sig = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_busy", {31'b0, bist_busy}, 32'd0);
    check("rst_done", {31'b0, bist_done}, 32'd0);
    check("rst_sig", {16'b0, bist_sig}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;

    // Test 1: all ones on every lane, 2-cycle latency.
    send_one({4{5'b11111}}, 8'b01010101, "t1");
    @(posedge clock); #1;

    // Test 2: lane0=00000, lane1=10010, lane2=11111, lane3=00000.
    send_one({5'b00000, 5'b11111, 5'b10010, 5'b00000}, 8'b00011100, "t2");
    @(posedge clock); #1;

    // Test 3: 10-beat stream with a downstream stall.
    stream = '{20'h00000, 20'hFFFFF, 20'h12345, 20'hABCDE, 20'h55555,
               20'hAAAAA, 20'h0F0F0, 20'hF0F0F, 20'h39C63, 20'hC639C};
    send_stream(stream, 1'b1);
    repeat (6) @(posedge clock); #1;
    check("t3_all_delivered", exp_q.size(), 0);

    // Test 4: BIST requested with two beats still in flight.
    stream = '{20'h13579, 20'h2468A};
    send_stream(stream, 1'b0);
    run_bist(1'b1, 3 + NPAT + STAGES, "t4");
    check("t4_beats_delivered", exp_q.size(), 0);
    sig_a = last_sig;

    // Test 5: repeat from DONE, then a different seed.
    run_bist(1'b1, 2 + NPAT + STAGES, "t5a");
    sig_b = last_sig;
    check("t5_repeat_equal", {16'b0, sig_b}, {16'b0, sig_a});
    bist_start2 = 1'b1;
    @(posedge clock); #1;
    bist_start2 = 1'b0;
    lat2 = -1;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clock);
      if (bist_done2) begin
        lat2 = k;
        break;
      end
    end
    check("t5_seed2_latency", lat2, 2 + NPAT + STAGES);
    check("t5_seed2_sig", {16'b0, bist_sig2}, {16'b0, bist_model(SEED2)});
    checks++;
    if (bist_sig2 === sig_a) begin
      errors++;
      $display("FAIL t5_seed_differs: got %h required value other than %h", bist_sig2, sig_a);
    end
    @(posedge clock); #1;

    // Test 6: reset in the middle of RUN.
    bist_start = 1'b1;
    @(posedge clock); #1;
    bist_start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("t6_busy", {31'b0, bist_busy}, 32'd0);
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_sig", {16'b0, bist_sig}, 32'd0);
    check("t6_done", {31'b0, bist_done}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_bist(1'b1, 2 + NPAT + STAGES, "t6");
    check("t6_sig_matches_t4", {16'b0, last_sig}, {16'b0, sig_a});

    check("sig_queue_empty", sig_q.size(), 0);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
